mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter XLEN, default 32: address width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive icache losses to dcache before icache wins one cycle.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  reset, asynchronous, active-low.
REQ-005 d_command  in  2  dcache request: BUS_NONE, BUS_LOAD or BUS_STORE.
REQ-006 d_addr  in  XLEN  dcache address.
REQ-007 d_data  in  64  dcache store data.
REQ-008 i_command  in  2  icache demand request, loads only.
REQ-009 i_addr  in  XLEN  icache address.
REQ-010 p_command  in  2  prefetch request, loads only.
REQ-011 p_addr  in  XLEN  prefetch address.
REQ-012 mem2proc_response  in  4  memory accept tag; 0 means rejected.
REQ-013 mem2proc_tag  in  4  completion tag; 0 means none.
REQ-014 mem2proc_data  in  64  completion data.
REQ-015 proc2mem_command, proc2mem_addr, proc2mem_data  out  2/XLEN/64  granted request.
REQ-016 d_response, i_response, p_response  out  4  accept tag to the granted requester; 0 to all others.
REQ-017 give_way  out  1  prefetch is requesting this cycle and is not granted.
REQ-018 d_done, i_done, p_done  out  1  one-hot completion strobe to the tag owner.
REQ-019 done_tag, done_data  out  4/64  completion tag and data, broadcast to all requesters.
REQ-020 inflight  out  5  number of outstanding tags.

Function
REQ-021 Grant is combinational each cycle: dcache first, then icache, then prefetch; BUS_NONE when nobody requests.
REQ-022 Starve counter: increments when icache requests and loses to dcache; clears when icache is granted or stops requesting.
REQ-023 When the starve counter is at least STARVE_LIMIT, icache outranks dcache for that cycle.
REQ-024 A loss that occurs with the starve counter already at STARVE_LIMIT holds it at STARVE_LIMIT; the counter never wraps.
REQ-025 Stores never allocate a tag; a store's accept tag is forwarded but not recorded.
REQ-026 Owner table: 16 entries, each a valid bit plus a 2-bit owner (D=0, I=1, P=2).
REQ-027 A granted load with mem2proc_response != 0 sets owner_table[mem2proc_response] at the next edge.
REQ-028 When mem2proc_tag != 0 and its entry is valid, the owner's done strobe is asserted in the same cycle and the entry is cleared at the next edge.
REQ-029 When mem2proc_tag names an invalid entry, no done strobe is asserted.
REQ-030 If the same tag completes and is allocated in one cycle, the completion is routed to the old owner and the allocation wins the table write.
REQ-031 inflight equals the count of valid owner-table entries: +1 on allocate, -1 on clear, unchanged when both happen.
REQ-032 When inflight = 15, all load grants are suppressed and give_way follows REQ-017.
REQ-033 Stores are still granted when inflight = 15.
REQ-034 proc2mem_data always carries d_data; its value is don't-care when dcache is not granted.

Reset
REQ-035 While reset = 0: owner table invalid, starve counter 0, inflight 0, all done strobes 0.
REQ-036 While reset = 0: proc2mem_command = BUS_NONE and all response outputs are 0, regardless of requests.
REQ-037 Assertion mid-operation drops every outstanding tag; completions arriving after reset produce no done strobe.

Structure
REQ-038 BUS_* encodings, the owner enumeration and the tag width live in the shared sys_defs package.
REQ-039 One sub-module, arb_owner_table, holds the owner table, the inflight counter and completion decode.

Verification
REQ-040 d LOAD 0x100 and i LOAD 0x200 together, response 3 -> dcache granted, d_response = 3, i_response = 0, owner[3] = D.
REQ-041 d requests every cycle while i requests, STARVE_LIMIT = 4 -> icache granted on the 5th cycle; the counter then clears.
REQ-042 p LOAD 0x300 alone, response 0 -> p_response = 0, no allocation, give_way = 0; with i also requesting -> give_way = 1.
REQ-043 p load accepted with tag 5, later mem2proc_tag = 5 with data 0xDEAD -> p_done = 1, done_data = 0xDEAD, inflight returns to 0.
REQ-044 Fill 15 tags -> load grants suppressed; a d STORE is still issued; one completion re-enables loads.
REQ-045 Reset with 3 tags outstanding, then mem2proc_tag = 2 -> no done strobe, inflight = 0.

Source files
------------

// File: rtl/sys_defs.sv
// Shared bus encodings, requester identities and tag sizing for the memory
// bus arbiter and its owner table.
package sys_defs;

  localparam int TAG_W    = 4;
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int CNT_W    = TAG_W + 1;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_t;

  typedef enum logic [1:0] {
    OWNER_D = 2'd0,
    OWNER_I = 2'd1,
    OWNER_P = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_D    = 2'd1,
    GNT_I    = 2'd2,
    GNT_P    = 2'd3
  } grant_t;

endpackage

// File: rtl/arb_owner_table.sv
// Tracks which requester owns each outstanding memory tag, counts the
// outstanding tags and decodes completions into per-requester strobes.
module arb_owner_table
  import sys_defs::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  owner_t           alloc_owner,
  input  logic [TAG_W-1:0] cpl_tag,
  output logic             d_done,
  output logic             i_done,
  output logic             p_done,
  output logic [CNT_W-1:0] inflight
);

  logic [NUM_TAGS-1:0] valid;
  owner_t              owner [NUM_TAGS];
  logic                cpl_hit;
  logic                alloc_new;

  assign cpl_hit = (cpl_tag != '0) && valid[cpl_tag];

  // Re-allocating a tag that is retiring this same cycle still adds one entry,
  // which cancels the retirement in the count.
  assign alloc_new = alloc_en &&
                     (!valid[alloc_tag] || (cpl_hit && (cpl_tag == alloc_tag)));

  always_comb begin
    d_done = 1'b0;
    i_done = 1'b0;
    p_done = 1'b0;
    if (cpl_hit) begin
      case (owner[cpl_tag])
        OWNER_D: d_done = 1'b1;
        OWNER_I: i_done = 1'b1;
        OWNER_P: p_done = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid    <= '0;
      inflight <= '0;
      for (int k = 0; k < NUM_TAGS; k++) owner[k] <= OWNER_D;
    end else begin
      if (cpl_hit) valid[cpl_tag] <= 1'b0;
      // Allocation is written after the clear so it wins on a shared tag.
      if (alloc_en) begin
        valid[alloc_tag] <= 1'b1;
        owner[alloc_tag] <= alloc_owner;
      end
      case ({alloc_new, cpl_hit})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority memory bus arbiter (dcache > icache > prefetch) with icache
// anti-starvation and tag-based completion routing.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       d_command,
  input  logic [XLEN-1:0]  d_addr,
  input  logic [63:0]      d_data,
  input  logic [1:0]       i_command,
  input  logic [XLEN-1:0]  i_addr,
  input  logic [1:0]       p_command,
  input  logic [XLEN-1:0]  p_addr,
  input  logic [3:0]       mem2proc_response,
  input  logic [3:0]       mem2proc_tag,
  input  logic [63:0]      mem2proc_data,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [3:0]       d_response,
  output logic [3:0]       i_response,
  output logic [3:0]       p_response,
  output logic             give_way,
  output logic             d_done,
  output logic             i_done,
  output logic             p_done,
  output logic [3:0]       done_tag,
  output logic [63:0]      done_data,
  output logic [4:0]       inflight
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve;
  logic            full, starved;
  logic            d_load, d_store, i_load, p_load;
  logic            d_ok, i_ok, p_ok;
  grant_t          grant;
  logic            alloc_en;
  owner_t          alloc_owner;

  assign full    = (inflight == CNT_W'(NUM_TAGS - 1));
  assign starved = (starve >= SC_W'(STARVE_LIMIT));
  assign d_load  = (d_command == BUS_LOAD);
  assign d_store = (d_command == BUS_STORE);
  assign i_load  = (i_command == BUS_LOAD);
  assign p_load  = (p_command == BUS_LOAD);

  // Loads need a free tag; stores never take one and pass even when full.
  assign d_ok = reset && (d_store || (d_load && !full));
  assign i_ok = reset && i_load && !full;
  assign p_ok = reset && p_load && !full;

  always_comb begin
    grant = GNT_NONE;
    if (starved && i_ok) grant = GNT_I;
    else if (d_ok)       grant = GNT_D;
    else if (i_ok)       grant = GNT_I;
    else if (p_ok)       grant = GNT_P;
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    d_response       = '0;
    i_response       = '0;
    p_response       = '0;
    alloc_owner      = OWNER_D;
    alloc_en         = 1'b0;
    case (grant)
      GNT_D: begin
        proc2mem_command = d_command;
        proc2mem_addr    = d_addr;
        d_response       = mem2proc_response;
        alloc_en         = d_load;
      end
      GNT_I: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = i_addr;
        i_response       = mem2proc_response;
        alloc_owner      = OWNER_I;
        alloc_en         = 1'b1;
      end
      GNT_P: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = p_addr;
        p_response       = mem2proc_response;
        alloc_owner      = OWNER_P;
        alloc_en         = 1'b1;
      end
      default: ;
    endcase
    if (mem2proc_response == '0) alloc_en = 1'b0;
  end

  assign proc2mem_data = d_data;
  assign give_way      = reset && p_load && (grant != GNT_P);
  assign done_tag      = mem2proc_tag;
  assign done_data     = mem2proc_data;

  // Any icache request that dcache beats counts as a loss, including stores
  // granted while icache loads are blocked by a full tag table.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (!i_load || (grant == GNT_I)) begin
      starve <= '0;
    end else if ((grant == GNT_D) && (starve < SC_W'(STARVE_LIMIT))) begin
      starve <= starve + SC_W'(1);
    end
  end

  arb_owner_table u_owner_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (alloc_owner),
    .cpl_tag     (mem2proc_tag),
    .d_done      (d_done),
    .i_done      (i_done),
    .p_done      (p_done),
    .inflight    (inflight)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: priority, starvation relief, prefetch
// give-way, completion routing, full-table behaviour and reset flushing.
module tb_mem_bus_arbiter;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  d_command, i_command, p_command;
  logic [31:0] d_addr, i_addr, p_addr;
  logic [63:0] d_data, mem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data, done_data;
  logic [3:0]  d_response, i_response, p_response, done_tag;
  logic        give_way, d_done, i_done, p_done;
  logic [4:0]  inflight;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .d_command(d_command), .d_addr(d_addr), .d_data(d_data),
    .i_command(i_command), .i_addr(i_addr),
    .p_command(p_command), .p_addr(p_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .d_response(d_response), .i_response(i_response), .p_response(p_response),
    .give_way(give_way), .d_done(d_done), .i_done(i_done), .p_done(p_done),
    .done_tag(done_tag), .done_data(done_data), .inflight(inflight)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic drive_idle;
    d_command = C_NONE; i_command = C_NONE; p_command = C_NONE;
    d_addr = 32'h100; i_addr = 32'h200; p_addr = 32'h300;
    d_data = 64'h0; mem2proc_data = 64'h0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
  endtask

  task automatic test_reset;
    drive_idle();
    reset = 1'b0;
    d_command = C_LOAD; i_command = C_LOAD; p_command = C_LOAD;
    mem2proc_response = 4'd7; mem2proc_tag = 4'd3;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (proc2mem_command !== C_NONE) begin failures++; $display("FAIL rst_cmd got=%0d exp=%0d", proc2mem_command, C_NONE); end
    checks++; if ({d_response, i_response, p_response} !== 12'h000) begin failures++; $display("FAIL rst_resp got=%h exp=000", {d_response, i_response, p_response}); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
    checks++; if ({d_done, i_done, p_done} !== 3'b000) begin failures++; $display("FAIL rst_done got=%b exp=000", {d_done, i_done, p_done}); end
    @(negedge clock);
    drive_idle();
    reset = 1'b1;
  endtask

  task automatic test_priority;
    @(negedge clock);
    drive_idle();
    d_command = C_LOAD; d_addr = 32'h100; i_command = C_LOAD; i_addr = 32'h200;
    mem2proc_response = 4'd3;
    #1;
    checks++; if (proc2mem_command !== C_LOAD) begin failures++; $display("FAIL prio_cmd got=%0d exp=%0d", proc2mem_command, C_LOAD); end
    checks++; if (proc2mem_addr !== 32'h100) begin failures++; $display("FAIL prio_addr got=%h exp=00000100", proc2mem_addr); end
    checks++; if (d_response !== 4'd3) begin failures++; $display("FAIL prio_d_resp got=%0d exp=3", d_response); end
    checks++; if (i_response !== 4'd0) begin failures++; $display("FAIL prio_i_resp got=%0d exp=0", i_response); end
    @(negedge clock);
    drive_idle();
    #1;
    checks++; if (inflight !== 5'd1) begin failures++; $display("FAIL prio_inflight got=%0d exp=1", inflight); end
    mem2proc_tag = 4'd3; mem2proc_data = 64'h1234;
    #1;
    checks++; if ({d_done, i_done, p_done} !== 3'b100) begin failures++; $display("FAIL prio_owner_d got=%b exp=100", {d_done, i_done, p_done}); end
    checks++; if (done_tag !== 4'd3) begin failures++; $display("FAIL prio_done_tag got=%0d exp=3", done_tag); end
    @(negedge clock);
    drive_idle();
    #1;
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL prio_drain got=%0d exp=0", inflight); end
  endtask

  task automatic test_starvation;
    logic [31:0] exp_addr;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      drive_idle();
      d_command = C_LOAD; i_command = C_LOAD;
      #1;
      exp_addr = (c == 4) ? 32'h200 : 32'h100;
      checks++; if (proc2mem_addr !== exp_addr) begin failures++; $display("FAIL starve_cycle%0d got=%h exp=%h", c, proc2mem_addr, exp_addr); end
    end
    @(negedge clock);
    drive_idle();
  endtask

  task automatic test_prefetch;
    @(negedge clock);
    drive_idle();
    p_command = C_LOAD;
    #1;
    checks++; if (proc2mem_addr !== 32'h300) begin failures++; $display("FAIL pf_addr got=%h exp=00000300", proc2mem_addr); end
    checks++; if (p_response !== 4'd0) begin failures++; $display("FAIL pf_resp0 got=%0d exp=0", p_response); end
    checks++; if (give_way !== 1'b0) begin failures++; $display("FAIL pf_giveway_alone got=%b exp=0", give_way); end
    @(negedge clock);
    i_command = C_LOAD;
    #1;
    checks++; if (give_way !== 1'b1) begin failures++; $display("FAIL pf_giveway_i got=%b exp=1", give_way); end
    checks++; if (proc2mem_addr !== 32'h200) begin failures++; $display("FAIL pf_i_addr got=%h exp=00000200", proc2mem_addr); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL pf_no_alloc got=%0d exp=0", inflight); end
    @(negedge clock);
    drive_idle();
    p_command = C_LOAD; mem2proc_response = 4'd5;
    #1;
    checks++; if (p_response !== 4'd5) begin failures++; $display("FAIL pf_resp5 got=%0d exp=5", p_response); end
    @(negedge clock);
    drive_idle();
    #1;
    checks++; if (inflight !== 5'd1) begin failures++; $display("FAIL pf_inflight1 got=%0d exp=1", inflight); end
    mem2proc_tag = 4'd9; mem2proc_data = 64'hBEEF;
    #1;
    checks++; if ({d_done, i_done, p_done} !== 3'b000) begin failures++; $display("FAIL pf_invalid_tag got=%b exp=000", {d_done, i_done, p_done}); end
    @(negedge clock);
    drive_idle();
    mem2proc_tag = 4'd5; mem2proc_data = 64'hDEAD;
    #1;
    checks++; if ({d_done, i_done, p_done} !== 3'b001) begin failures++; $display("FAIL pf_done got=%b exp=001", {d_done, i_done, p_done}); end
    checks++; if (done_data !== 64'hDEAD) begin failures++; $display("FAIL pf_done_data got=%h exp=dead", done_data); end
    @(negedge clock);
    drive_idle();
    #1;
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL pf_drain got=%0d exp=0", inflight); end
  endtask

  task automatic test_full;
    for (int t = 1; t <= 15; t++) begin
      @(negedge clock);
      drive_idle();
      d_command = C_LOAD; d_addr = 32'h1000 + 32'(t); mem2proc_response = 4'(t);
    end
    @(negedge clock);
    drive_idle();
    #1;
    checks++; if (inflight !== 5'd15) begin failures++; $display("FAIL full_inflight got=%0d exp=15", inflight); end
    d_command = C_LOAD; i_command = C_LOAD; p_command = C_LOAD;
    #1;
    checks++; if (proc2mem_command !== C_NONE) begin failures++; $display("FAIL full_suppress got=%0d exp=0", proc2mem_command); end
    checks++; if (give_way !== 1'b1) begin failures++; $display("FAIL full_giveway got=%b exp=1", give_way); end
    // Eleven cycles of icache losing to stores; the counter must saturate.
    @(negedge clock);
    drive_idle();
    d_command = C_STORE; d_addr = 32'h400; d_data = 64'hCAFE; i_command = C_LOAD;
    mem2proc_response = 4'd6;
    #1;
    checks++; if (proc2mem_command !== C_STORE) begin failures++; $display("FAIL full_store_cmd got=%0d exp=2", proc2mem_command); end
    checks++; if (proc2mem_data !== 64'hCAFE) begin failures++; $display("FAIL full_store_data got=%h exp=cafe", proc2mem_data); end
    checks++; if (d_response !== 4'd6) begin failures++; $display("FAIL full_store_resp got=%0d exp=6", d_response); end
    checks++; if (i_response !== 4'd0) begin failures++; $display("FAIL full_store_iresp got=%0d exp=0", i_response); end
    repeat (9) begin
      @(negedge clock);
      mem2proc_response = 4'd0;
    end
    @(negedge clock);
    mem2proc_tag = 4'd7;
    #1;
    checks++; if (inflight !== 5'd15) begin failures++; $display("FAIL full_store_noalloc got=%0d exp=15", inflight); end
    checks++; if ({d_done, i_done, p_done} !== 3'b100) begin failures++; $display("FAIL full_cpl7 got=%b exp=100", {d_done, i_done, p_done}); end
    @(negedge clock);
    drive_idle();
    d_command = C_LOAD; i_command = C_LOAD;
    #1;
    checks++; if (inflight !== 5'd14) begin failures++; $display("FAIL full_freed got=%0d exp=14", inflight); end
    checks++; if (proc2mem_command !== C_LOAD) begin failures++; $display("FAIL full_reenable got=%0d exp=1", proc2mem_command); end
    checks++; if (proc2mem_addr !== 32'h200) begin failures++; $display("FAIL starve_saturate got=%h exp=00000200", proc2mem_addr); end
    @(negedge clock);
    #1;
    checks++; if (proc2mem_addr !== 32'h100) begin failures++; $display("FAIL starve_clear got=%h exp=00000100", proc2mem_addr); end
    // Tag 4 retires (owned by dcache) while icache is granted tag 4.
    @(negedge clock);
    drive_idle();
    i_command = C_LOAD; mem2proc_response = 4'd4; mem2proc_tag = 4'd4;
    #1;
    checks++; if ({d_done, i_done, p_done} !== 3'b100) begin failures++; $display("FAIL same_tag_old_owner got=%b exp=100", {d_done, i_done, p_done}); end
    checks++; if (i_response !== 4'd4) begin failures++; $display("FAIL same_tag_iresp got=%0d exp=4", i_response); end
    @(negedge clock);
    drive_idle();
    #1;
    checks++; if (inflight !== 5'd14) begin failures++; $display("FAIL same_tag_count got=%0d exp=14", inflight); end
    mem2proc_tag = 4'd4;
    #1;
    checks++; if ({d_done, i_done, p_done} !== 3'b010) begin failures++; $display("FAIL same_tag_new_owner got=%b exp=010", {d_done, i_done, p_done}); end
    @(negedge clock);
    drive_idle();
    #1;
    checks++; if (inflight !== 5'd13) begin failures++; $display("FAIL same_tag_drain got=%0d exp=13", inflight); end
  endtask

  task automatic test_reset_midflight;
    @(negedge clock);
    drive_idle();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clock);
      drive_idle();
      d_command = C_LOAD; mem2proc_response = 4'(t);
    end
    @(negedge clock);
    drive_idle();
    #1;
    checks++; if (inflight !== 5'd3) begin failures++; $display("FAIL mid_inflight3 got=%0d exp=3", inflight); end
    reset = 1'b0;
    #1;
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL mid_async_clear got=%0d exp=0", inflight); end
    @(negedge clock);
    reset = 1'b1;
    mem2proc_tag = 4'd2;
    #1;
    checks++; if ({d_done, i_done, p_done} !== 3'b000) begin failures++; $display("FAIL mid_no_done got=%b exp=000", {d_done, i_done, p_done}); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL mid_inflight0 got=%0d exp=0", inflight); end
    @(negedge clock);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_starvation();
    test_prefetch();
    test_full();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
